// File: rtl/count_monitor.sv
// Count-interface receiver: checks that each strobed sample is prev+1 (mod 2^WIDTH), locks after LOCK_CNT good steps.
// Optional: COUNT_MONITOR_RESTART_TOL_EN tolerates a zero sample in LOCKED as an upstream counter restart.
module count_monitor #(
  parameter int WIDTH    = 4,
  parameter int LOCK_CNT = 4,
  parameter int ERR_W    = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] count_in,
  input  logic             valid_in,
  input  logic             clear_err,
  output logic             locked,
  output logic             err_pulse,
  output logic             wrap_pulse,
  output logic             restart_pulse,
  output logic [WIDTH-1:0] expected,
  output logic [ERR_W-1:0] err_count
);

  typedef enum logic [1:0] {IDLE, ACQ, LOCKED} state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] prev, prev_n, prev_inc;
  logic [7:0]       run, run_n;
  logic [8:0]       run_inc;
  logic             match, err_n, wrap_n;
`ifdef COUNT_MONITOR_RESTART_TOL_EN
  logic             restart_n;
`endif

  assign prev_inc = prev + 1'b1;
  assign match    = (count_in == prev_inc);
  assign run_inc  = {1'b0, run} + 9'd1;
  assign locked   = (state == LOCKED);

  always_comb begin
    state_n = state;
    prev_n  = prev;
    run_n   = run;
    err_n   = 1'b0;
    wrap_n  = 1'b0;
`ifdef COUNT_MONITOR_RESTART_TOL_EN
    restart_n = 1'b0;
`endif
    if (valid_in) begin
      prev_n = count_in;
      case (state)
        IDLE: begin
          run_n   = '0;
          state_n = ACQ;
        end
        ACQ: begin
          if (match) begin
            run_n = run_inc[7:0];
            if (run_inc == 9'(LOCK_CNT)) state_n = LOCKED;
          end else begin
            run_n = '0;
          end
        end
        LOCKED: begin
          if (match) begin
            wrap_n = &prev;
          end else begin
            state_n = ACQ;
            run_n   = '0;
`ifdef COUNT_MONITOR_RESTART_TOL_EN
            // A zero sample here means the producer restarted, not a glitch
            if (count_in == '0) restart_n = 1'b1;
            else                err_n     = 1'b1;
`else
            err_n = 1'b1;
`endif
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      prev       <= '0;
      run        <= '0;
      expected   <= '0;
      err_pulse  <= 1'b0;
      wrap_pulse <= 1'b0;
      err_count  <= '0;
    end else begin
      state      <= state_n;
      prev       <= prev_n;
      run        <= run_n;
      err_pulse  <= err_n;
      wrap_pulse <= wrap_n;
      if (valid_in) expected <= count_in + 1'b1;
      // Clear beats a simultaneous error; tally saturates instead of wrapping
      if (clear_err)                   err_count <= '0;
      else if (err_n && ~&err_count)   err_count <= err_count + 1'b1;
    end
  end

`ifdef COUNT_MONITOR_RESTART_TOL_EN
  always_ff @(posedge clk) begin
    if (!reset) restart_pulse <= 1'b0;
    else        restart_pulse <= restart_n;
  end
`else
  assign restart_pulse = 1'b0;
`endif

endmodule
